// File: rtl/nx_stream_upsizer_if.sv
// Handshake bundle for the narrow-to-wide stream upsizer: narrow inbound
// stream (s_*) and packed wide outbound stream (m_*).
interface nx_stream_upsizer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 128
);
    logic [IN_WIDTH-1:0]    s_tdata;
    logic                   s_tlast;
    logic                   s_tvalid;
    logic                   s_tready;
    logic [OUT_WIDTH-1:0]   m_tdata;
    logic [OUT_WIDTH/8-1:0] m_tkeep;
    logic                   m_tlast;
    logic                   m_tvalid;
    logic                   m_tready;

    // The upsizer itself: consumes the narrow stream, produces the wide one.
    modport slave (
        input  s_tdata, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
    );

    // The surrounding environment: drives narrow beats, sinks wide words.
    modport master (
        output s_tdata, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tkeep, m_tlast, m_tvalid
    );
endinterface

// File: rtl/nx_stream_upsizer.sv
// Packs narrow AXI4-stream beats little-endian into wide words; short frames
// are closed with zero lanes and a lane-granular byte keep mask.
module nx_stream_upsizer #(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 128,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    nx_stream_upsizer_if.slave     bus,
    output logic [COUNT_WIDTH-1:0] status_frames,
    output logic                   status_busy
);
    localparam int RATIO      = OUT_WIDTH / IN_WIDTH;
    localparam int LANE_W     = $clog2(RATIO);
    localparam int KEEP_W     = OUT_WIDTH / 8;
    localparam int LANE_BYTES = IN_WIDTH / 8;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]               lane;
    logic [RATIO-2:0][IN_WIDTH-1:0]  slot_data;
    logic [RATIO-2:0]                slot_valid;
    logic [OUT_WIDTH-1:0]            out_data;
    logic [KEEP_W-1:0]               out_keep;
    logic                            out_last;
    logic                            out_valid;

    logic                            accept;
    logic                            completing;
    logic [OUT_WIDTH-1:0]            word;
    logic [KEEP_W-1:0]               word_keep;
    logic [LANE_W-1:0]               lane_nxt;
    logic                            valid_nxt;

    // A completing beat may only wait on a full output register that is not draining.
    assign bus.s_tready = rstn & (((lane != LAST_LANE) & ~bus.s_tlast) | ~out_valid | bus.m_tready);

    assign bus.m_tdata  = out_data;
    assign bus.m_tkeep  = out_keep;
    assign bus.m_tlast  = out_last;
    assign bus.m_tvalid = out_valid;

    always_comb begin
        accept     = bus.s_tvalid & bus.s_tready;
        completing = (lane == LAST_LANE) | bus.s_tlast;
        word       = '0;
        word_keep  = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (slot_valid[k]) begin
                word[k*IN_WIDTH +: IN_WIDTH]        = slot_data[k];
                word_keep[k*LANE_BYTES +: LANE_BYTES] = '1;
            end
        end
        word[lane*IN_WIDTH +: IN_WIDTH]          = bus.s_tdata;
        word_keep[lane*LANE_BYTES +: LANE_BYTES] = '1;

        lane_nxt  = lane;
        valid_nxt = out_valid;
        if (accept) begin
            lane_nxt = completing ? '0 : lane + LANE_W'(1);
        end
        if (accept & completing) begin
            valid_nxt = 1'b1;
        end else if (out_valid & bus.m_tready) begin
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane          <= '0;
            slot_data     <= '0;
            slot_valid    <= '0;
            out_data      <= '0;
            out_keep      <= '0;
            out_last      <= 1'b0;
            out_valid     <= 1'b0;
            status_frames <= '0;
            status_busy   <= 1'b0;
        end else begin
            lane        <= lane_nxt;
            out_valid   <= valid_nxt;
            status_busy <= (lane_nxt != '0) | valid_nxt;

            if (accept & completing) begin
                slot_valid <= '0;
                out_data   <= word;
                out_keep   <= word_keep;
                out_last   <= bus.s_tlast;
            end else if (accept) begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (lane == LANE_W'(k)) begin
                        slot_data[k]  <= bus.s_tdata;
                        slot_valid[k] <= 1'b1;
                    end
                end
            end

            if (out_valid & bus.m_tready & out_last) begin
                status_frames <= status_frames + COUNT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_nx_stream_upsizer.sv
// Directed bench for nx_stream_upsizer; a second instance with a 2-bit frame
// counter shadows the same stimulus to exercise counter wrap.
module tb_nx_stream_upsizer;
    logic clk;
    logic rstn;
    int   tests;
    int   fails;

    logic [15:0] frames;
    logic        busy;
    logic [1:0]  frames_w;
    logic        busy_w;

    nx_stream_upsizer_if #(.IN_WIDTH(32), .OUT_WIDTH(128)) bus ();
    nx_stream_upsizer_if #(.IN_WIDTH(32), .OUT_WIDTH(128)) bus_w ();

    assign bus_w.s_tdata  = bus.s_tdata;
    assign bus_w.s_tlast  = bus.s_tlast;
    assign bus_w.s_tvalid = bus.s_tvalid;
    assign bus_w.m_tready = bus.m_tready;

    nx_stream_upsizer #(.IN_WIDTH(32), .OUT_WIDTH(128), .COUNT_WIDTH(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus),
        .status_frames (frames),
        .status_busy   (busy)
    );

    nx_stream_upsizer #(.IN_WIDTH(32), .OUT_WIDTH(128), .COUNT_WIDTH(2)) dut_w (
        .clk           (clk),
        .rstn          (rstn),
        .bus           (bus_w),
        .status_frames (frames_w),
        .status_busy   (busy_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [127:0] data, input logic [15:0] keep, input logic last);
        checkOutput({tag, " m_tvalid"}, 128'(bus.m_tvalid), 128'(1'b1));
        checkOutput({tag, " m_tdata"}, bus.m_tdata, data);
        checkOutput({tag, " m_tkeep"}, 128'(bus.m_tkeep), 128'(keep));
        checkOutput({tag, " m_tlast"}, 128'(bus.m_tlast), 128'(last));
    endtask

    // Present one beat and return at #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [31:0] data, input logic last);
        int waited;
        waited        = 0;
        bus.s_tdata   = data;
        bus.s_tlast   = last;
        bus.s_tvalid  = 1'b1;
        @(negedge clk);
        while (!bus.s_tready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("s_tready handshake", 128'(bus.s_tready), 128'(1'b1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tests        = 0;
        fails        = 0;
        rstn         = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tlast  = 1'b0;
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset m_tvalid", 128'(bus.m_tvalid), 128'(1'b0));
        checkOutput("reset m_tlast", 128'(bus.m_tlast), 128'(1'b0));
        checkOutput("reset m_tdata", bus.m_tdata, 128'h0);
        checkOutput("reset m_tkeep", 128'(bus.m_tkeep), 128'h0);
        checkOutput("reset s_tready", 128'(bus.s_tready), 128'(1'b0));
        checkOutput("reset frames", 128'(frames), 128'h0);
        checkOutput("reset busy", 128'(busy), 128'(1'b0));
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Full word
        bus.m_tready = 1'b1;
        applyStimulus(32'h11111111, 1'b0);
        checkOutput("full busy after beat 1", 128'(busy), 128'(1'b1));
        applyStimulus(32'h22222222, 1'b0);
        applyStimulus(32'h33333333, 1'b0);
        applyStimulus(32'h44444444, 1'b1);
        checkWord("full", 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1);
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("full frames", 128'(frames), 128'd1);
        checkOutput("full drained", 128'(bus.m_tvalid), 128'(1'b0));
        checkOutput("full busy idle", 128'(busy), 128'(1'b0));

        // Short frame
        applyStimulus(32'hAAAA0001, 1'b0);
        applyStimulus(32'hBBBB0002, 1'b1);
        checkWord("short", 128'h00000000_00000000_BBBB0002_AAAA0001, 16'h00FF, 1'b1);
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("short frames", 128'(frames), 128'd2);

        // Multi-word frame of six beats
        applyStimulus(32'd1, 1'b0);
        applyStimulus(32'd2, 1'b0);
        applyStimulus(32'd3, 1'b0);
        applyStimulus(32'd4, 1'b0);
        checkWord("multi w1", 128'h00000004_00000003_00000002_00000001, 16'hFFFF, 1'b0);
        applyStimulus(32'd5, 1'b0);
        applyStimulus(32'd6, 1'b1);
        checkWord("multi w2", 128'h00000000_00000000_00000006_00000005, 16'h00FF, 1'b1);
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("multi frames", 128'(frames), 128'd3);

        // Backpressure: eight beats with the sink stalled
        bus.m_tready = 1'b0;
        applyStimulus(32'hB0000001, 1'b0);
        applyStimulus(32'hB0000002, 1'b0);
        applyStimulus(32'hB0000003, 1'b0);
        applyStimulus(32'hB0000004, 1'b0);
        checkWord("bp w1", 128'hB0000004_B0000003_B0000002_B0000001, 16'hFFFF, 1'b0);
        applyStimulus(32'hB0000005, 1'b0);
        applyStimulus(32'hB0000006, 1'b0);
        applyStimulus(32'hB0000007, 1'b0);
        bus.s_tdata  = 32'hB0000008;
        bus.s_tlast  = 1'b1;
        bus.s_tvalid = 1'b1;
        @(negedge clk);
        checkOutput("bp s_tready on beat 8", 128'(bus.s_tready), 128'(1'b0));
        repeat (2) @(posedge clk);
        #1;
        checkOutput("bp s_tready held low", 128'(bus.s_tready), 128'(1'b0));
        checkWord("bp w1 held", 128'hB0000004_B0000003_B0000002_B0000001, 16'hFFFF, 1'b0);
        bus.m_tready = 1'b1;
        applyStimulus(32'hB0000008, 1'b1);
        checkWord("bp w2", 128'hB0000008_B0000007_B0000006_B0000005, 16'hFFFF, 1'b1);
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("bp frames", 128'(frames), 128'd4);
        checkOutput("bp drained", 128'(bus.m_tvalid), 128'(1'b0));

        // Reset in the middle of a frame
        applyStimulus(32'hDEAD0001, 1'b0);
        applyStimulus(32'hDEAD0002, 1'b0);
        bus.s_tvalid = 1'b0;
        checkOutput("midreset busy before", 128'(busy), 128'(1'b1));
        rstn = 1'b0;
        #1;
        checkOutput("midreset m_tvalid", 128'(bus.m_tvalid), 128'(1'b0));
        checkOutput("midreset m_tdata", bus.m_tdata, 128'h0);
        checkOutput("midreset m_tkeep", 128'(bus.m_tkeep), 128'h0);
        checkOutput("midreset frames", 128'(frames), 128'h0);
        checkOutput("midreset busy", 128'(busy), 128'(1'b0));
        checkOutput("midreset s_tready", 128'(bus.s_tready), 128'(1'b0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(32'd9, 1'b0);
        applyStimulus(32'd10, 1'b0);
        applyStimulus(32'd11, 1'b0);
        applyStimulus(32'd12, 1'b1);
        checkWord("midreset word", 128'h0000000C_0000000B_0000000A_00000009, 16'hFFFF, 1'b1);
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset frames after", 128'(frames), 128'd1);

        // Counter wrap on the 2-bit instance with back-to-back single-beat frames
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(32'hC0DE0000 + 32'(i), 1'b1);
            checkOutput("wrap frames", 128'(frames_w), 128'((i - 1) % 4));
            checkOutput("wrap m_tkeep", 128'(bus_w.m_tkeep), 128'h000F);
            checkOutput("wrap m_tdata", bus_w.m_tdata, 128'(32'hC0DE0000 + 32'(i)));
            checkOutput("wrap m_tvalid", 128'(bus_w.m_tvalid), 128'(1'b1));
        end
        bus.s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("wrap frames final", 128'(frames_w), 128'd1);
        checkOutput("wrap busy final", 128'(busy_w), 128'(1'b0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
